score_display: RTL and testbench
================================

SCORE_DISPLAY -- requirements
Module: score_display

Interface
REQ-001 Parameter X0, default 16: left pixel column of both digit rows.
REQ-002 Parameter Y0, default 8: top pixel line of the current-score row.
REQ-003 Parameter ROW_PITCH, default 32: vertical offset from the current-score row to the high-score row.
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 score  input  16  packed BCD score, digit 3 in [15:12], digit 0 in [3:0].
REQ-007 game_start  input  1  one-cycle pulse, new game begins.
REQ-008 game_over  input  1  one-cycle pulse, game ends.
REQ-009 frame_tick  input  1  one-cycle end-of-frame pulse, 60 Hz.
REQ-010 hpos, vpos  input  10 each  current pixel coordinates from the video timing block.
REQ-011 display_on  input  1  high inside the visible area.
REQ-012 pixel_on  output  1  registered glyph pixel.
REQ-013 hi_score  output  16  packed BCD high score.
REQ-014 new_high  output  1  set when the last game_over produced a new high score.

Function
REQ-015 The block SHALL capture score into an internal shadow register only on cycles with frame_tick=1; rendering SHALL use only the shadow register.
REQ-016 On game_over, if score > hi_score as unsigned 16-bit values, the block SHALL load hi_score<=score and set new_high<=1 on the next edge; otherwise both SHALL hold.
REQ-017 game_start SHALL clear new_high; when game_start and game_over coincide, the game_over result SHALL win.
REQ-018 Equal scores SHALL NOT count as a new high.
REQ-019 Layout: row 0 (shadow score) at y∈[Y0,Y0+24); row 1 (hi_score) at y∈[Y0+ROW_PITCH, Y0+ROW_PITCH+24).
REQ-020 Each row SHALL hold 4 cells of 16x24 px starting at X0, with digit 3 leftmost; local coordinates are lx=hpos-cell_left and ly=vpos-row_top.
REQ-021 Segment regions, half-open ranges:
  - a: ly[0,2), lx[2,10)
  - b: lx[10,12), ly[2,10)
  - c: lx[10,12), ly[12,20)
  - d: ly[20,22), lx[2,10)
  - e: lx[0,2), ly[12,20)
  - f: lx[0,2), ly[2,10)
  - g: ly[10,12), lx[2,10)
  - All other cell pixels are blank.
REQ-022 Digits 0-9 SHALL use standard 7-segment encoding, with 6, 7 and 9 drawn as a+f+g+e+d+c, a+b+c and a+b+c+d+f+g respectively.
REQ-023 Digit values 10-15 SHALL render blank; REQ-016 compare still uses raw bits.
REQ-024 Row 0 SHALL suppress leading zeros (digits 3..1 blank while they and all digits to their left are 0); digit 0 SHALL always render.
REQ-025 Row 1 SHALL render all 4 digits, including zeros.
REQ-026 A 5-bit blink counter SHALL increment on each frame_tick and wrap 31->0.
REQ-027 While new_high=1, row 1 SHALL be blanked when counter bit 4 = 1.
REQ-028 pixel_on SHALL reflect the hpos/vpos/display_on of the previous cycle (latency 1).
REQ-029 pixel_on SHALL be forced to 0 when display_on=0 or when the coordinates are outside both rows.
REQ-030 The block SHALL contain no combinational path from any input to any output.

Reset
REQ-031 While rst_n=0, the block SHALL hold pixel_on=0, hi_score=16'h0000, new_high=0, shadow register=0 and blink counter=0.
REQ-032 Reset asserted mid-frame SHALL take effect immediately; after release, row 0 SHALL render "0" until the next frame_tick.

Verification
REQ-033 Reset scenario: after release, pixel_on=0, hi_score=0000 and new_high=0.
REQ-034 Digit scenario: score=0042 then frame_tick; hpos=X0+52, vpos=Y0 (segment a of '2') -> pixel_on=1 one cycle later; hpos=X0+4, vpos=Y0 (suppressed digit 3) -> 0.
REQ-035 High-score scenario: hi=0099 and game_over with score=0120 -> hi_score=0120, new_high=1; a later game_over with 0050 -> hi_score=0120 unchanged; game_start -> new_high=0.
REQ-036 Shadow scenario: score changes 0042->0043 with no frame_tick -> row 0 pixels unchanged; after frame_tick, '3' is rendered.
REQ-037 Blink scenario: with new_high=1, row 1 pixels are visible for blink counter 0-15 and blank for 16-31; with new_high=0, row 1 is always visible.
REQ-038 Blanking scenario: digit nibble 4'hA -> cell blank; display_on=0 over a lit segment -> pixel_on=0.

Source files
------------

// File: rtl/score_display.sv
`default_nettype none
// ---------------------------------------------------------------------------
// score_display: draws the current and high BCD scores as 7-segment glyphs.
// Revision: 1.0
// ---------------------------------------------------------------------------
module score_display #(
  parameter int X0        = 16,
  parameter int Y0        = 8,
  parameter int ROW_PITCH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] score,
  input  logic        game_start,
  input  logic        game_over,
  input  logic        frame_tick,
  input  logic [9:0]  hpos,
  input  logic [9:0]  vpos,
  input  logic        display_on,
  output logic        pixel_on,
  output logic [15:0] hi_score,
  output logic        new_high
);

  localparam logic [9:0] c_X_LEFT  = 10'(X0);
  localparam logic [9:0] c_X_RIGHT = 10'(X0 + 64);
  localparam logic [9:0] c_R0_TOP  = 10'(Y0);
  localparam logic [9:0] c_R0_BOT  = 10'(Y0 + 24);
  localparam logic [9:0] c_R1_TOP  = 10'(Y0 + ROW_PITCH);
  localparam logic [9:0] c_R1_BOT  = 10'(Y0 + ROW_PITCH + 24);

  logic [15:0] shadow_q, shadow_d;
  logic [4:0]  blink_q,  blink_d;
  logic [15:0] hi_q,     hi_d;
  logic        new_high_q, new_high_d;
  logic        pixel_on_q, pixel_on_d;

  // Segment set of a digit, ordered {a,b,c,d,e,f,g}; 10-15 are blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0:    s = 7'b1111110;
      4'h1:    s = 7'b0110000;
      4'h2:    s = 7'b1101101;
      4'h3:    s = 7'b1111001;
      4'h4:    s = 7'b0110011;
      4'h5:    s = 7'b1011011;
      4'h6:    s = 7'b1011111;
      4'h7:    s = 7'b1110000;
      4'h8:    s = 7'b1111111;
      4'h9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // Which segment regions contain the cell-local point, ordered {a,b,c,d,e,f,g}.
  function automatic logic [6:0] seg_region(input logic [3:0] lx, input logic [4:0] ly);
    logic x_left, x_mid, x_right;
    logic y_top, y_upper, y_mid, y_lower, y_bot;
    x_left  = (lx < 4'd2);
    x_mid   = (lx >= 4'd2) && (lx < 4'd10);
    x_right = (lx >= 4'd10) && (lx < 4'd12);
    y_top   = (ly < 5'd2);
    y_upper = (ly >= 5'd2) && (ly < 5'd10);
    y_mid   = (ly >= 5'd10) && (ly < 5'd12);
    y_lower = (ly >= 5'd12) && (ly < 5'd20);
    y_bot   = (ly >= 5'd20) && (ly < 5'd22);
    return {y_top & x_mid, x_right & y_upper, x_right & y_lower, y_bot & x_mid,
            x_left & y_lower, x_left & y_upper, y_mid & x_mid};
  endfunction

  function automatic logic [3:0] nibble(input logic [15:0] v, input logic [1:0] idx);
    logic [3:0] n;
    case (idx)
      2'd3:    n = v[15:12];
      2'd2:    n = v[11:8];
      2'd1:    n = v[7:4];
      default: n = v[3:0];
    endcase
    return n;
  endfunction

  logic       w_in_x, w_in_r0, w_in_r1;
  logic [5:0] w_dx;
  logic [1:0] w_cell, w_idx;
  logic [3:0] w_lx;
  logic [4:0] w_ly0, w_ly1;
  logic [3:0] w_lz;

  assign w_in_x  = (hpos >= c_X_LEFT) && (hpos < c_X_RIGHT);
  assign w_in_r0 = (vpos >= c_R0_TOP) && (vpos < c_R0_BOT);
  assign w_in_r1 = (vpos >= c_R1_TOP) && (vpos < c_R1_BOT);
  assign w_dx    = 6'(hpos - c_X_LEFT);
  assign w_cell  = w_dx[5:4];
  assign w_lx    = w_dx[3:0];
  assign w_idx   = 2'd3 - w_cell;
  assign w_ly0   = 5'(vpos - c_R0_TOP);
  assign w_ly1   = 5'(vpos - c_R1_TOP);

  // Leading-zero suppression chain for row 0; digit 0 is never suppressed.
  assign w_lz[3] = (shadow_q[15:12] == 4'h0);
  assign w_lz[2] = w_lz[3] && (shadow_q[11:8] == 4'h0);
  assign w_lz[1] = w_lz[2] && (shadow_q[7:4] == 4'h0);
  assign w_lz[0] = 1'b0;

  logic [15:0] w_row_val;
  logic [4:0]  w_ly;
  logic        w_blank;
  logic [3:0]  w_digit;

  always_comb begin
    w_row_val = shadow_q;
    w_ly      = w_ly0;
    w_blank   = w_lz[w_idx];
    if (!w_in_r0 && w_in_r1) begin
      w_row_val = hi_q;
      w_ly      = w_ly1;
      w_blank   = new_high_q && blink_q[4];
    end
    w_digit    = nibble(w_row_val, w_idx);
    pixel_on_d = display_on && w_in_x && (w_in_r0 || w_in_r1) && !w_blank &&
                 (|(seg_decode(w_digit) & seg_region(w_lx, w_ly)));
  end

  always_comb begin
    shadow_d   = shadow_q;
    blink_d    = blink_q;
    hi_d       = hi_q;
    new_high_d = new_high_q;
    if (frame_tick) begin
      shadow_d = score;
      blink_d  = blink_q + 5'd1;
    end
    // game_over takes precedence over a coincident game_start.
    if (game_over) begin
      if (score > hi_q) begin
        hi_d       = score;
        new_high_d = 1'b1;
      end
    end else if (game_start) begin
      new_high_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q   <= 16'h0000;
      blink_q    <= 5'd0;
      hi_q       <= 16'h0000;
      new_high_q <= 1'b0;
      pixel_on_q <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      blink_q    <= blink_d;
      hi_q       <= hi_d;
      new_high_q <= new_high_d;
      pixel_on_q <= pixel_on_d;
    end
  end

  assign pixel_on = pixel_on_q;
  assign hi_score = hi_q;
  assign new_high = new_high_q;

endmodule
`default_nettype wire

// File: tb/tb_score_display.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_score_display: scoreboard-driven bench for score_display.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_score_display;

  localparam int X0 = 16;
  localparam int Y0 = 8;
  localparam int RP = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] score = 16'h0000;
  logic        game_start = 1'b0;
  logic        game_over = 1'b0;
  logic        frame_tick = 1'b0;
  logic [9:0]  hpos = 10'd0;
  logic [9:0]  vpos = 10'd0;
  logic        display_on = 1'b0;
  logic        pixel_on;
  logic [15:0] hi_score;
  logic        new_high;

  int n_checks = 0;
  int n_fail   = 0;
  int blink_m  = 0;
  bit nh_m     = 1'b0;

  bit          pix_q[$];
  logic [16:0] hs_q[$];

  always #5 clk = ~clk;

  score_display #(.X0(X0), .Y0(Y0), .ROW_PITCH(RP)) dut (
    .clk(clk), .rst_n(rst_n), .score(score), .game_start(game_start),
    .game_over(game_over), .frame_tick(frame_tick), .hpos(hpos), .vpos(vpos),
    .display_on(display_on), .pixel_on(pixel_on), .hi_score(hi_score),
    .new_high(new_high)
  );

  task automatic tick();
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    blink_m = (blink_m + 1) % 32;
  endtask

  task automatic drive_pix(input int x, input int y, input bit on, input bit exp);
    @(negedge clk);
    hpos = 10'(x); vpos = 10'(y); display_on = on;
    pix_q.push_back(exp);
    @(negedge clk);
  endtask

  task automatic pulse(input logic [15:0] s, input bit go, input bit gs, input logic [16:0] exp);
    @(negedge clk);
    score = s; game_over = go; game_start = gs;
    hs_q.push_back(exp);
    @(negedge clk);
    game_over = 1'b0; game_start = 1'b0;
  endtask

  task automatic test_reset();
    int tx[4] = '{X0+52, X0+52, X0+4, X0+4};
    int ty[4] = '{Y0,    Y0+10, Y0,   Y0+RP};
    bit te[4] = '{1'b1,  1'b0,  1'b0, 1'b1};
    bit w; logic [16:0] wh;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    hs_q.push_back(17'h0); pix_q.push_back(1'b0);
    wh = hs_q.pop_front(); w = pix_q.pop_front(); n_checks += 2;
    if ({new_high, hi_score} !== wh) begin n_fail++; $display("FAIL reset_hold_hs got=%h want=%h", {new_high, hi_score}, wh); end
    if (pixel_on !== w) begin n_fail++; $display("FAIL reset_hold_pix got=%b want=%b", pixel_on, w); end
    rst_n = 1'b1; blink_m = 0;
    @(negedge clk);
    hs_q.push_back(17'h0); pix_q.push_back(1'b0);
    wh = hs_q.pop_front(); w = pix_q.pop_front(); n_checks += 2;
    if ({new_high, hi_score} !== wh) begin n_fail++; $display("FAIL reset_rel_hs got=%h want=%h", {new_high, hi_score}, wh); end
    if (pixel_on !== w) begin n_fail++; $display("FAIL reset_rel_pix got=%b want=%b", pixel_on, w); end
    for (int i = 0; i < 4; i++) begin
      drive_pix(tx[i], ty[i], 1'b1, te[i]);
      w = pix_q.pop_front(); n_checks++;
      if (pixel_on !== w) begin n_fail++; $display("FAIL reset_zero[%0d] got=%b want=%b", i, pixel_on, w); end
    end
    // Mid-frame reset with non-zero state.
    pulse(16'h0001, 1'b1, 1'b0, {1'b1, 16'h0001});
    wh = hs_q.pop_front(); n_checks++;
    if ({new_high, hi_score} !== wh) begin n_fail++; $display("FAIL pre_rst_hs got=%h want=%h", {new_high, hi_score}, wh); end
    score = 16'h0007; tick();
    drive_pix(X0+52, Y0, 1'b1, 1'b1);
    w = pix_q.pop_front(); n_checks++;
    if (pixel_on !== w) begin n_fail++; $display("FAIL pre_rst_pix got=%b want=%b", pixel_on, w); end
    #2 rst_n = 1'b0;
    #1;
    hs_q.push_back(17'h0); pix_q.push_back(1'b0);
    wh = hs_q.pop_front(); w = pix_q.pop_front(); n_checks += 2;
    if ({new_high, hi_score} !== wh) begin n_fail++; $display("FAIL midrst_hs got=%h want=%h", {new_high, hi_score}, wh); end
    if (pixel_on !== w) begin n_fail++; $display("FAIL midrst_pix got=%b want=%b", pixel_on, w); end
    @(negedge clk); rst_n = 1'b1; blink_m = 0;
    // Shadow cleared: '0' has segment d, the stale '7' does not.
    drive_pix(X0+52, Y0+20, 1'b1, 1'b1);
    w = pix_q.pop_front(); n_checks++;
    if (pixel_on !== w) begin n_fail++; $display("FAIL midrst_shadow got=%b want=%b", pixel_on, w); end
  endtask

  task automatic test_digits();
    int tx[12] = '{X0+52, X0+4, X0+16, X0+36, X0+32, X0+48,  X0+58,  X0+52,  X0+52,  X0+57, X0+58, X0+64};
    int ty[12] = '{Y0,    Y0,   Y0+4,  Y0,    Y0+4,  Y0+14,  Y0+14,  Y0+21,  Y0+22,  Y0,    Y0,    Y0+14};
    bit te[12] = '{1'b1,  1'b0, 1'b0,  1'b0,  1'b1,  1'b1,   1'b0,   1'b1,   1'b0,   1'b1,  1'b0,  1'b0};
    int ux[3]  = '{X0+36, X0+4, X0+26};
    int uy[3]  = '{Y0,    Y0,   Y0+4};
    bit ue[3]  = '{1'b1,  1'b0, 1'b1};
    bit w;
    score = 16'h0042; tick();
    for (int i = 0; i < 12; i++) begin
      drive_pix(tx[i], ty[i], 1'b1, te[i]);
      w = pix_q.pop_front(); n_checks++;
      if (pixel_on !== w) begin n_fail++; $display("FAIL digits_0042[%0d] got=%b want=%b", i, pixel_on, w); end
    end
    score = 16'h0102; tick();
    for (int i = 0; i < 3; i++) begin
      drive_pix(ux[i], uy[i], 1'b1, ue[i]);
      w = pix_q.pop_front(); n_checks++;
      if (pixel_on !== w) begin n_fail++; $display("FAIL digits_0102[%0d] got=%b want=%b", i, pixel_on, w); end
    end
  endtask

  task automatic test_shadow();
    bit w;
    score = 16'h0042; tick();
    score = 16'h0043;
    repeat (3) @(negedge clk);
    drive_pix(X0+48, Y0+14, 1'b1, 1'b1);
    w = pix_q.pop_front(); n_checks++;
    if (pixel_on !== w) begin n_fail++; $display("FAIL shadow_hold_e got=%b want=%b", pixel_on, w); end
    drive_pix(X0+58, Y0+14, 1'b1, 1'b0);
    w = pix_q.pop_front(); n_checks++;
    if (pixel_on !== w) begin n_fail++; $display("FAIL shadow_hold_c got=%b want=%b", pixel_on, w); end
    tick();
    drive_pix(X0+48, Y0+14, 1'b1, 1'b0);
    w = pix_q.pop_front(); n_checks++;
    if (pixel_on !== w) begin n_fail++; $display("FAIL shadow_upd_e got=%b want=%b", pixel_on, w); end
    drive_pix(X0+58, Y0+14, 1'b1, 1'b1);
    w = pix_q.pop_front(); n_checks++;
    if (pixel_on !== w) begin n_fail++; $display("FAIL shadow_upd_c got=%b want=%b", pixel_on, w); end
  endtask

  task automatic test_high_score();
    logic [15:0] ps[8] = '{16'h0099, 16'h0120, 16'h0050, 16'h0000, 16'h0120, 16'h0119, 16'h0200, 16'h0A00};
    bit          go[8] = '{1'b1,     1'b1,     1'b1,     1'b0,     1'b1,     1'b1,     1'b1,     1'b1};
    bit          gs[8] = '{1'b0,     1'b0,     1'b0,     1'b1,     1'b0,     1'b0,     1'b1,     1'b0};
    logic [16:0] ex[8] = '{17'h10099, 17'h10120, 17'h10120, 17'h00120, 17'h00120, 17'h00120, 17'h10200, 17'h10A00};
    logic [16:0] wh;
    for (int i = 0; i < 8; i++) begin
      pulse(ps[i], go[i], gs[i], ex[i]);
      wh = hs_q.pop_front(); n_checks++;
      if ({new_high, hi_score} !== wh) begin n_fail++; $display("FAIL high_score[%0d] got=%h want=%h", i, {new_high, hi_score}, wh); end
    end
    nh_m = 1'b1;
  endtask

  task automatic test_blink();
    bit w; logic [16:0] wh;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 32; i++) begin
        drive_pix(X0+4, Y0+RP, 1'b1, !(nh_m && (blink_m >= 16)));
        w = pix_q.pop_front(); n_checks++;
        if (pixel_on !== w) begin n_fail++; $display("FAIL blink[%0d/%0d] cnt=%0d got=%b want=%b", pass, i, blink_m, pixel_on, w); end
        tick();
      end
      pulse(16'h0000, 1'b0, 1'b1, {1'b0, 16'h0A00});
      wh = hs_q.pop_front(); n_checks++;
      if ({new_high, hi_score} !== wh) begin n_fail++; $display("FAIL blink_clear got=%h want=%h", {new_high, hi_score}, wh); end
      nh_m = 1'b0;
    end
  endtask

  task automatic test_blanking();
    int tx[8] = '{X0+20, X0+16,   X0+36, X0+36, X0+32, X0+52, X0+58, X0+52};
    int ty[8] = '{Y0+RP, Y0+RP+4, Y0+RP, Y0,    Y0+4,  Y0,    Y0+4,  Y0+28};
    bit te[8] = '{1'b0,  1'b0,    1'b1,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0};
    bit w;
    score = 16'h00A5; tick();
    for (int i = 0; i < 8; i++) begin
      drive_pix(tx[i], ty[i], 1'b1, te[i]);
      w = pix_q.pop_front(); n_checks++;
      if (pixel_on !== w) begin n_fail++; $display("FAIL blanking[%0d] got=%b want=%b", i, pixel_on, w); end
    end
    drive_pix(X0+52, Y0, 1'b0, 1'b0);
    w = pix_q.pop_front(); n_checks++;
    if (pixel_on !== w) begin n_fail++; $display("FAIL blank_display_off got=%b want=%b", pixel_on, w); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_digits();
    test_shadow();
    test_high_score();
    test_blink();
    test_blanking();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
